fifo_ctrl_ext: RTL

Parametrised circular-queue controller for a register-file FIFO, and the next generation of the team's basic FIFO controller. It supports any depth, not just powers of two. It adds an occupancy count, almost-full and almost-empty thresholds, qualified accept strobes and sticky overflow/underflow error flags. It drives the read and write addresses of an external register file and sits between a producer/consumer pair and that storage.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/fifo_ptr.sv | 28 ++
 rtl/fifo_ctrl_ext.sv | 85 ++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the fifo_ctrl_ext circular-queue controller.
package fifo_pkg;

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
    } fifo_status_t;

    // Explicit wrap so non-power-of-two depths never rely on 2^AW rollover.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

    function automatic int aw_of(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cw_of(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// One wrapping address pointer: advances by one on inc, DEPTH-1 wraps to 0.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     inc,
    output logic [aw_of(DEPTH)-1:0]  ptr
);
    localparam int AW = aw_of(DEPTH);

    logic [AW-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc) ptr_d = AW'(ptr_inc(32'(ptr_q), DEPTH));
    end

    always_ff @(posedge clk) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/fifo_ctrl_ext.sv
// FIFO controller for an external register file: pointers, occupancy count,
// registered threshold flags and sticky overflow/underflow errors.
module fifo_ctrl_ext
    import fifo_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int ALMOST_FULL  = DEPTH - 2,
    parameter int ALMOST_EMPTY = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rd,
    input  logic                     wr,
    input  logic                     clr_err,
    output logic                     we,
    output logic                     re,
    output logic [aw_of(DEPTH)-1:0]  w_addr,
    output logic [aw_of(DEPTH)-1:0]  r_addr,
    output logic [cw_of(DEPTH)-1:0]  count,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int CW = cw_of(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL);
    localparam logic [CW-1:0] AE_C    = CW'(ALMOST_EMPTY);

    logic [CW-1:0] count_q, count_d;
    fifo_status_t  status_q, status_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    function automatic fifo_status_t status_of(input logic [CW-1:0] c);
        fifo_status_t s;
        s.empty        = (c == '0);
        s.full         = (c == DEPTH_C);
        s.almost_empty = (c <= AE_C);
        s.almost_full  = (c >= AF_C);
        return s;
    endfunction

    // A full FIFO still accepts a write when a read frees a slot the same edge.
    assign we = wr & (~status_q.full | rd);
    assign re = rd & ~status_q.empty;

    always_comb begin
        count_d = count_q;
        if (we & ~re)      count_d = count_q + 1'b1;
        else if (re & ~we) count_d = count_q - 1'b1;
        status_d    = status_of(count_d);
        // A new error event wins over a coincident clear.
        overflow_d  = (wr & ~we) | (overflow_q & ~clr_err);
        underflow_d = (rd & ~re) | (underflow_q & ~clr_err);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= '0;
            status_q    <= status_of('0);
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            status_q    <= status_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_ptr #(.DEPTH(DEPTH)) u_wptr (.clk(clk), .reset(reset), .inc(we), .ptr(w_addr));
    fifo_ptr #(.DEPTH(DEPTH)) u_rptr (.clk(clk), .reset(reset), .inc(re), .ptr(r_addr));

    assign count        = count_q;
    assign empty        = status_q.empty;
    assign full         = status_q.full;
    assign almost_empty = status_q.almost_empty;
    assign almost_full  = status_q.almost_full;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
